// File: rtl/sdf_delay_line_if.sv
// Beat-level bus of the SDF delay line: input/feedback beats in, paired
// delayed/current beats and status flags out.
interface sdf_delay_line_if #(
  parameter int DATA_WIDTH = 9,
  parameter int LANES      = 16
);
  logic [LANES-1:0][DATA_WIDTH-1:0] din_re;
  logic [LANES-1:0][DATA_WIDTH-1:0] din_im;
  logic [LANES-1:0][DATA_WIDTH-1:0] fb_re;
  logic [LANES-1:0][DATA_WIDTH-1:0] fb_im;
  logic [LANES-1:0][DATA_WIDTH-1:0] dly_re;
  logic [LANES-1:0][DATA_WIDTH-1:0] dly_im;
  logic [LANES-1:0][DATA_WIDTH-1:0] cur_re;
  logic [LANES-1:0][DATA_WIDTH-1:0] cur_im;
  logic                             valid;
  logic                             bfly_valid;
  logic                             fb_valid;
  logic                             frame_done;

  modport master (
    output din_re, din_im, fb_re, fb_im, valid,
    input  dly_re, dly_im, cur_re, cur_im, bfly_valid, fb_valid, frame_done
  );

  modport slave (
    input  din_re, din_im, fb_re, fb_im, valid,
    output dly_re, dly_im, cur_re, cur_im, bfly_valid, fb_valid, frame_done
  );
endinterface

// File: rtl/sdf_delay_line.sv
// Multi-lane delay buffer for one radix-2 SDF FFT stage: pairs each half-block
// with the one before it and optionally replays butterfly feedback.
module sdf_delay_line #(
  parameter int DATA_WIDTH = 9,
  parameter int LANES      = 16,
  parameter int DEPTH      = 128,
  parameter int FRAME_LEN  = 512,
  parameter int FEEDBACK   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  sdf_delay_line_if.slave bus_io
);
  localparam int HALF  = DEPTH / LANES;
  localparam int FB    = FRAME_LEN / LANES;
  localparam int CNT_W = (FB > 1) ? $clog2(FB) : 1;

  typedef logic [LANES-1:0][DATA_WIDTH-1:0] beat_t;

  if ((LANES < 1) || ((DEPTH % LANES) != 0) || ((FRAME_LEN % (2 * DEPTH)) != 0)) begin : g_bad_cfg
    $error("sdf_delay_line: illegal LANES/DEPTH/FRAME_LEN combination");
  end

  beat_t            mem_re_q [HALF];
  beat_t            mem_im_q [HALF];
  logic             tag_q    [HALF];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  beat_t            dly_re_q, dly_re_d, dly_im_q, dly_im_d;
  beat_t            cur_re_q, cur_re_d, cur_im_q, cur_im_d;
  logic             bfly_q, bfly_d, fbv_q, fbv_d, done_q, done_d;
  logic             accept_s, phase_s;
  logic [CNT_W-1:0] half_idx_s;
  beat_t            head_re_s, head_im_s;

  // Next-state decode: clear drops the beat and restarts the frame in FILL.
  always_comb begin
    accept_s   = bus_io.valid & ~clear_i;
    half_idx_s = cnt_q / CNT_W'(HALF);
    phase_s    = half_idx_s[0];
    cnt_d      = cnt_q;
    dly_re_d   = dly_re_q;
    dly_im_d   = dly_im_q;
    cur_re_d   = cur_re_q;
    cur_im_d   = cur_im_q;
    bfly_d     = 1'b0;
    fbv_d      = 1'b0;
    done_d     = 1'b0;
    if (phase_s && (FEEDBACK != 0)) begin
      head_re_s = bus_io.fb_re;
      head_im_s = bus_io.fb_im;
    end else begin
      head_re_s = bus_io.din_re;
      head_im_s = bus_io.din_im;
    end
    if (clear_i) begin
      cnt_d = '0;
    end else if (accept_s) begin
      cnt_d    = (cnt_q == CNT_W'(FB - 1)) ? '0 : cnt_q + CNT_W'(1);
      dly_re_d = mem_re_q[HALF-1];
      dly_im_d = mem_im_q[HALF-1];
      cur_re_d = bus_io.din_re;
      cur_im_d = bus_io.din_im;
      bfly_d   = phase_s;
      fbv_d    = (FEEDBACK != 0) && !phase_s && tag_q[HALF-1];
      done_d   = (cnt_q == CNT_W'(FB - 1));
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Sample shift chain; contents survive clear and are only overwritten by beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < HALF; i++) begin
        mem_re_q[i] <= '0;
        mem_im_q[i] <= '0;
      end
    end else if (accept_s) begin
      mem_re_q[0] <= head_re_s;
      mem_im_q[0] <= head_im_s;
      for (int i = 1; i < HALF; i++) begin
        mem_re_q[i] <= mem_re_q[i-1];
        mem_im_q[i] <= mem_im_q[i-1];
      end
    end
  end

  // Replay tags mark entries written in PAIR; clear invalidates all of them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clear_i) begin
      for (int i = 0; i < HALF; i++) begin
        tag_q[i] <= 1'b0;
      end
    end else if (accept_s) begin
      tag_q[0] <= phase_s;
      for (int i = 1; i < HALF; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Frame counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      dly_re_q <= '0;
      dly_im_q <= '0;
      cur_re_q <= '0;
      cur_im_q <= '0;
      bfly_q   <= 1'b0;
      fbv_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      dly_re_q <= dly_re_d;
      dly_im_q <= dly_im_d;
      cur_re_q <= cur_re_d;
      cur_im_q <= cur_im_d;
      bfly_q   <= bfly_d;
      fbv_q    <= fbv_d;
      done_q   <= done_d;
    end
  end

  assign bus_io.dly_re     = dly_re_q;
  assign bus_io.dly_im     = dly_im_q;
  assign bus_io.cur_re     = cur_re_q;
  assign bus_io.cur_im     = cur_im_q;
  assign bus_io.bfly_valid = bfly_q;
  assign bus_io.fb_valid   = fbv_q;
  assign bus_io.frame_done = done_q;
endmodule

// File: tb/tb_sdf_delay_line.sv
// Bench for sdf_delay_line: three instances (16-lane no feedback, 16-lane feedback,
// 8-lane 12-bit) share one directed sequence and are checked against a scoreboard.
module tb_sdf_delay_line;
  typedef logic [15:0][15:0] beat_t;
  typedef struct packed { beat_t dre; beat_t dim; beat_t cre; beat_t cim; logic bv; logic fv; logic fd; } out_t;
  typedef struct packed { beat_t re; beat_t im; logic tag; } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  sdf_delay_line_if #(.DATA_WIDTH(9),  .LANES(16)) if0 ();
  sdf_delay_line_if #(.DATA_WIDTH(9),  .LANES(16)) if1 ();
  sdf_delay_line_if #(.DATA_WIDTH(12), .LANES(8))  if2 ();

  sdf_delay_line #(.FEEDBACK(0)) u0 (.clk(clk), .rst(rst), .clear_i(clear), .bus_io(if0.slave));
  sdf_delay_line #(.FEEDBACK(1)) u1 (.clk(clk), .rst(rst), .clear_i(clear), .bus_io(if1.slave));
  sdf_delay_line #(.DATA_WIDTH(12), .LANES(8), .DEPTH(64), .FRAME_LEN(256), .FEEDBACK(0))
    u2 (.clk(clk), .rst(rst), .clear_i(clear), .bus_io(if2.slave));

  int   lanes_c [3] = '{16, 16, 8};
  int   dw_c    [3] = '{9, 9, 12};
  bit   fbk_c   [3] = '{1'b0, 1'b1, 1'b0};
  ent_t hist [3][8];
  out_t last [3];
  out_t sbq  [$];
  int   ptr, cnt, label;
  int   vectors, miscompares;

  function automatic beat_t norm(input beat_t b, input int lanes, input int dw);
    beat_t r;
    logic signed [15:0] t;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      if (k < lanes) begin
        t = $signed(b[k] << (16 - dw));
        t = t >>> (16 - dw);
        r[k] = t;
      end
    end
    return r;
  endfunction

  function automatic beat_t negb(input beat_t b);
    beat_t r;
    for (int k = 0; k < 16; k++) r[k] = -b[k];
    return r;
  endfunction

  // kind 0: 16-lane ramp; kind 2: 8-lane alternating-sign values near +/-2047
  function automatic beat_t gen(input int kind, input bit im, input int b);
    beat_t r;
    int mag;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      if (kind == 0) begin
        r[k] = im ? 16'(b * 7 - k * 5) : 16'(b * 16 + k);
      end else if (k < 8) begin
        mag = 2047 - ((b * 8 + k) % 64);
        r[k] = (((b + k) % 2 == 1) ^ im) ? 16'(-mag) : 16'(mag);
      end
    end
    return r;
  endfunction

  function automatic out_t obs(input int i);
    out_t o;
    o = '0;
    case (i)
      0: begin
        for (int k = 0; k < 16; k++) begin
          o.dre[k] = 16'($signed(if0.dly_re[k])); o.dim[k] = 16'($signed(if0.dly_im[k]));
          o.cre[k] = 16'($signed(if0.cur_re[k])); o.cim[k] = 16'($signed(if0.cur_im[k]));
        end
        o.bv = if0.bfly_valid; o.fv = if0.fb_valid; o.fd = if0.frame_done;
      end
      1: begin
        for (int k = 0; k < 16; k++) begin
          o.dre[k] = 16'($signed(if1.dly_re[k])); o.dim[k] = 16'($signed(if1.dly_im[k]));
          o.cre[k] = 16'($signed(if1.cur_re[k])); o.cim[k] = 16'($signed(if1.cur_im[k]));
        end
        o.bv = if1.bfly_valid; o.fv = if1.fb_valid; o.fd = if1.frame_done;
      end
      default: begin
        for (int k = 0; k < 8; k++) begin
          o.dre[k] = 16'($signed(if2.dly_re[k])); o.dim[k] = 16'($signed(if2.dly_im[k]));
          o.cre[k] = 16'($signed(if2.cur_re[k])); o.cim[k] = 16'($signed(if2.cur_im[k]));
        end
        o.bv = if2.bfly_valid; o.fv = if2.fb_valid; o.fd = if2.frame_done;
      end
    endcase
    return o;
  endfunction

  task automatic cmp(input int i, input string tag, input logic [255:0] ob, input logic [255:0] ex);
    vectors++;
    assert (ob === ex) else begin
      miscompares++;
      $error("FAIL u%0d %s label=%0d observed=%h expected=%h", i, tag, label, ob, ex);
    end
  endtask

  task automatic cmp_all(input int i, input out_t o, input out_t e);
    cmp(i, "dly_re", o.dre, e.dre);
    cmp(i, "dly_im", o.dim, e.dim);
    cmp(i, "cur_re", o.cre, e.cre);
    cmp(i, "cur_im", o.cim, e.cim);
    cmp(i, "flags(bv,fv,fd)", 256'({o.bv, o.fv, o.fd}), 256'({e.bv, e.fv, e.fd}));
  endtask

  task automatic check_now();
    for (int i = 0; i < 3; i++) cmp_all(i, obs(i), last[i]);
  endtask

  task automatic reset_model();
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 8; j++) hist[i][j] = '0;
      last[i] = '0;
    end
    ptr = 0;
    cnt = 0;
    sbq.delete();
  endtask

  // One cycle: drive inputs, advance the model, push expectations, then check after the edge.
  task automatic step(input bit v, input bit clr);
    beat_t d_re [3];
    beat_t d_im [3];
    beat_t f_re [3];
    beat_t f_im [3];
    ent_t  tail;
    bit    phase;
    out_t  e;
    d_re[0] = norm(gen(0, 1'b0, label), 16, 9);
    d_im[0] = norm(gen(0, 1'b1, label), 16, 9);
    d_re[1] = d_re[0];
    d_im[1] = d_im[0];
    d_re[2] = norm(gen(2, 1'b0, label), 8, 12);
    d_im[2] = norm(gen(2, 1'b1, label), 8, 12);
    for (int i = 0; i < 3; i++) begin
      f_re[i] = norm(negb(d_re[i]), lanes_c[i], dw_c[i]);
      f_im[i] = norm(negb(d_im[i]), lanes_c[i], dw_c[i]);
    end
    for (int k = 0; k < 16; k++) begin
      if0.din_re[k] = d_re[0][k][8:0]; if0.din_im[k] = d_im[0][k][8:0];
      if0.fb_re[k]  = f_re[0][k][8:0]; if0.fb_im[k]  = f_im[0][k][8:0];
      if1.din_re[k] = d_re[1][k][8:0]; if1.din_im[k] = d_im[1][k][8:0];
      if1.fb_re[k]  = f_re[1][k][8:0]; if1.fb_im[k]  = f_im[1][k][8:0];
    end
    for (int k = 0; k < 8; k++) begin
      if2.din_re[k] = d_re[2][k][11:0]; if2.din_im[k] = d_im[2][k][11:0];
      if2.fb_re[k]  = f_re[2][k][11:0]; if2.fb_im[k]  = f_im[2][k][11:0];
    end
    if0.valid = v; if1.valid = v; if2.valid = v;
    clear = clr;
    if (clr) begin
      cnt = 0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 8; j++) hist[i][j].tag = 1'b0;
        last[i].bv = 1'b0; last[i].fv = 1'b0; last[i].fd = 1'b0;
      end
    end else if (v) begin
      phase = ((cnt / 8) % 2) == 1;
      for (int i = 0; i < 3; i++) begin
        tail = hist[i][ptr];
        hist[i][ptr].re  = (phase && fbk_c[i]) ? f_re[i] : d_re[i];
        hist[i][ptr].im  = (phase && fbk_c[i]) ? f_im[i] : d_im[i];
        hist[i][ptr].tag = phase;
        e.dre = tail.re;  e.dim = tail.im;
        e.cre = d_re[i];  e.cim = d_im[i];
        e.bv  = phase;
        e.fv  = fbk_c[i] && !phase && tail.tag;
        e.fd  = (cnt == 31);
        last[i] = e;
      end
      ptr = (ptr + 1) % 8;
      cnt = (cnt + 1) % 32;
      label++;
    end else begin
      for (int i = 0; i < 3; i++) begin
        last[i].bv = 1'b0; last[i].fv = 1'b0; last[i].fd = 1'b0;
      end
    end
    for (int i = 0; i < 3; i++) sbq.push_back(last[i]);
    @(negedge clk);
    for (int i = 0; i < 3; i++) cmp_all(i, obs(i), sbq.pop_front());
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    label = 0;
    if0.din_re = '0; if0.din_im = '0; if0.fb_re = '0; if0.fb_im = '0; if0.valid = 1'b0;
    if1.din_re = '0; if1.din_im = '0; if1.fb_re = '0; if1.fb_im = '0; if1.valid = 1'b0;
    if2.din_re = '0; if2.din_im = '0; if2.fb_re = '0; if2.fb_im = '0; if2.valid = 1'b0;
    reset_model();
    repeat (2) @(negedge clk);
    check_now();
    rst = 1'b0;
    // Frame 1 plus the first FILL half of frame 2 (feedback replay window)
    repeat (40) step(1'b1, 1'b0);
    // Gaps before beats 11 and 7
    repeat (3) step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    repeat (28) step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b0);
    // Clear collides with beat 12
    step(1'b1, 1'b1);
    repeat (20) step(1'b1, 1'b0);
    // Asynchronous reset in the middle of beat 20
    if0.valid = 1'b1; if1.valid = 1'b1; if2.valid = 1'b1;
    #2 rst = 1'b1;
    #1 reset_model();
    check_now();
    @(negedge clk);
    check_now();
    rst = 1'b0;
    repeat (12) step(1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
